ecc_apb_master: RTL and testbench

APB initiator that drives the ECC accelerator's register interface from a simple command/response handshake. Each accepted command is turned into four fixed-order APB writes (DATA_IN, CODEWORD_WIDTH, NOISE, CTRL). The block then waits for `operation_done`, captures `data_out` and `num_of_errors`, and returns them on a response handshake. It sits between a host/sequencer and `ecc_enc_dec`, on the opposite side of the APB bus.

---
 rtl/ecc_apb_master_if.sv | 54 +++++
 rtl/ecc_apb_master.sv | 218 +++++++++++++++++++++
 tb/tb_ecc_apb_master.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_apb_master_if.sv
// ecc_apb_master_if: bundles the command handshake, the APB write bus,
// the accelerator completion inputs and the response handshake.
// The master modport is the initiator's view; slave is the view of
// whoever sits on the other side (sequencer, accelerator, test bench).
interface ecc_apb_master_if #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32
);
  // Command handshake
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [1:0]                 cmd_op;
  logic [DATA_WIDTH-1:0]      cmd_data;
  logic [1:0]                 cmd_width;
  logic [AMBA_WORD-1:0]       cmd_noise;

  // APB write bus
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PWDATA;

  // Accelerator results
  logic [DATA_WIDTH-1:0]      data_out;
  logic                       operation_done;
  logic [1:0]                 num_of_errors;

  // Response handshake
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic [1:0]                 rsp_errors;
  logic                       rsp_fail;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, cmd_width, cmd_noise,
    output cmd_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  data_out, operation_done, num_of_errors,
    output rsp_valid, rsp_data, rsp_errors, rsp_fail,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, cmd_width, cmd_noise,
    input  cmd_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output data_out, operation_done, num_of_errors,
    input  rsp_valid, rsp_data, rsp_errors, rsp_fail,
    output rsp_ready
  );
endinterface

// File: rtl/ecc_apb_master.sv
// ecc_apb_master: turns one command into four APB writes to the ECC
// accelerator (DATA_IN, CODEWORD_WIDTH, NOISE, CTRL), waits for
// operation_done, and returns the captured result on a response handshake.
// CTRL goes last because writing it starts the accelerator.
// Optional feature: define ECC_APB_TIMEOUT_EN to bound the wait for
// operation_done to TIMEOUT_CYCLES cycles; on expiry the response reports
// rsp_fail with zeroed data. Without the macro the wait is unbounded.
module ecc_apb_master #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32
`ifdef ECC_APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES  = 1024
`endif
) (
  input logic             clk,
  input logic             reset,
  ecc_apb_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_ENCODE  = 2'd0,
    OP_DECODE  = 2'd1,
    OP_FULL    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL    = AMBA_ADDR_WIDTH'(8'h00);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN = AMBA_ADDR_WIDTH'(8'h04);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CW      = AMBA_ADDR_WIDTH'(8'h08);
  localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE   = AMBA_ADDR_WIDTH'(8'h0C);
  localparam logic [1:0]                 LAST_IDX     = 2'd3;

  state_e                     state_q;
  logic [1:0]                 idx_q;
  logic [1:0]                 op_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [1:0]                 width_q;
  logic [AMBA_WORD-1:0]       noise_q;

  logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
  logic [AMBA_WORD-1:0]       pwdata_q;
  logic                       psel_q;
  logic                       penable_q;
  logic                       pwrite_q;

  logic                       rsp_valid_q;
  logic [DATA_WIDTH-1:0]      rsp_data_q;
  logic [1:0]                 rsp_errors_q;
  logic                       rsp_fail_q;

`ifdef ECC_APB_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]           cnt_q;
`endif

  // Register address for write slot idx; the order is fixed so CTRL is last.
  function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] idx);
    case (idx)
      2'd0: reg_addr = ADDR_DATA_IN;
      2'd1: reg_addr = ADDR_CW;
      2'd2: reg_addr = ADDR_NOISE;
      2'd3: reg_addr = ADDR_CTRL;
    endcase
  endfunction

  // Write data for slot idx, zero-extended to the bus width.
  function automatic logic [AMBA_WORD-1:0] reg_wdata(
    input logic [1:0]            idx,
    input logic [DATA_WIDTH-1:0] d,
    input logic [1:0]            w,
    input logic [AMBA_WORD-1:0]  n,
    input logic [1:0]            op
  );
    case (idx)
      2'd0: reg_wdata = AMBA_WORD'(d);
      2'd1: reg_wdata = AMBA_WORD'(w);
      2'd2: reg_wdata = n;
      2'd3: reg_wdata = AMBA_WORD'(op);
    endcase
  endfunction

  // Command sequencer: APB write train, completion wait, response hold.
  // NOTE: the asynchronous reset clears every register, including PADDR and
  // PWDATA, so a transfer cut by reset leaves PSEL/PENABLE low immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      op_q         <= '0;
      data_q       <= '0;
      width_q      <= '0;
      noise_q      <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_errors_q <= '0;
      rsp_fail_q   <= 1'b0;
`ifdef ECC_APB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments here mean every branch reads the
      // pre-edge register values, so outputs change together at the edge.
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            data_q  <= bus.cmd_data;
            width_q <= bus.cmd_width;
            noise_q <= bus.cmd_noise;
            idx_q   <= '0;
            if (bus.cmd_op == OP_ILLEGAL) begin
              state_q      <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_fail_q   <= 1'b1;
              rsp_data_q   <= '0;
              rsp_errors_q <= '0;
            end else begin
              // The latched copies are not visible yet, so slot 0 is built
              // straight from the command fields.
              state_q   <= S_SETUP;
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
              pwrite_q  <= 1'b1;
              paddr_q   <= reg_addr(2'd0);
              pwdata_q  <= reg_wdata(2'd0, bus.cmd_data, bus.cmd_width,
                                     bus.cmd_noise, bus.cmd_op);
            end
          end
        end

        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end

        S_ACCESS: begin
          // No PREADY: every access completes in this single cycle.
          if (idx_q != LAST_IDX) begin
            idx_q     <= idx_q + 2'd1;
            penable_q <= 1'b0;
            paddr_q   <= reg_addr(idx_q + 2'd1);
            pwdata_q  <= reg_wdata(idx_q + 2'd1, data_q, width_q, noise_q, op_q);
            state_q   <= S_SETUP;
          end else begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= S_WAIT_DONE;
`ifdef ECC_APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end

        S_WAIT_DONE: begin
          // Completion has priority over an expiring timeout.
          if (bus.operation_done) begin
            rsp_data_q   <= bus.data_out;
            rsp_errors_q <= bus.num_of_errors;
            rsp_fail_q   <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
`ifdef ECC_APB_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            rsp_data_q   <= '0;
            rsp_errors_q <= '0;
            rsp_fail_q   <= 1'b1;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // cmd_ready is the only output decoded from state rather than registered.
  assign bus.cmd_ready  = (state_q == S_IDLE);

  assign bus.PADDR      = paddr_q;
  assign bus.PWDATA     = pwdata_q;
  assign bus.PSEL       = psel_q;
  assign bus.PENABLE    = penable_q;
  assign bus.PWRITE     = pwrite_q;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_errors = rsp_errors_q;
  assign bus.rsp_fail   = rsp_fail_q;

endmodule

// File: tb/tb_ecc_apb_master.sv
// tb_ecc_apb_master: randomized scoreboard bench for ecc_apb_master.
// The command driver pushes the expected APB writes, the accelerator's
// planned answer and the expected response into queues; separate monitors
// for the APB bus, the accelerator side and the response port pop and
// compare. Build with ECC_APB_TIMEOUT_EN to also exercise the timeout.
module tb_ecc_apb_master;

  localparam int AW  = 32;
  localparam int ADW = 20;
  localparam int DW  = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ecc_apb_master_if #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW)) bus ();

`ifdef ECC_APB_TIMEOUT_EN
  ecc_apb_master #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW),
                   .TIMEOUT_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  ecc_apb_master #(.AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW), .DATA_WIDTH(DW))
    dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  typedef struct {
    logic [ADW-1:0] addr;
    logic [AW-1:0]  data;
  } apb_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    errs;
    logic          fail;
    bit            check_data;
  } rsp_exp_t;

  typedef struct {
    int            delay;   // cycles after CTRL write; <0 means never answer
    logic [DW-1:0] data;
    logic [1:0]    errs;
  } plan_t;

  apb_exp_t exp_apb[$];
  rsp_exp_t exp_rsp[$];
  plan_t    plan_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  bit   auto_ready   = 1'b1;
  logic manual_ready = 1'b0;
  logic rnd_ready    = 1'b0;
  bit   stray_en     = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  assign bus.rsp_ready = auto_ready ? rnd_ready : manual_ready;

  // Random consumer back-pressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1 rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Issue one command and push everything the reference predicts for it.
  task automatic send_cmd(input logic [1:0] op, input logic [DW-1:0] d,
                          input logic [1:0] w, input logic [AW-1:0] nz,
                          input int dly, input logic [DW-1:0] rd,
                          input logic [1:0] re);
    bit       acc;
    bit       done;
    apb_exp_t a;
    rsp_exp_t r;
    plan_t    p;
    @(posedge clk);
    #1;
    // NOTE: stimulus is driven with blocking assignments after the edge so
    // the DUT sees stable values at the next rising edge.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_width = w;
    bus.cmd_noise = nz;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_data  = $urandom;
    bus.cmd_width = 2'($urandom);
    bus.cmd_noise = $urandom;
    if (!done) begin
      check("cmd_accept_timeout", 0, 1);
    end else if (op == 2'd3) begin
      r = '{data: '0, errs: '0, fail: 1'b1, check_data: 1'b0};
      exp_rsp.push_back(r);
    end else begin
      a = '{addr: 20'h04, data: d};          exp_apb.push_back(a);
      a = '{addr: 20'h08, data: {30'd0, w}};  exp_apb.push_back(a);
      a = '{addr: 20'h0C, data: nz};          exp_apb.push_back(a);
      a = '{addr: 20'h00, data: {30'd0, op}}; exp_apb.push_back(a);
      p = '{delay: dly, data: rd, errs: re};
      plan_q.push_back(p);
      if (dly < 0) r = '{data: '0, errs: '0, fail: 1'b1, check_data: 1'b1};
      else         r = '{data: rd, errs: re, fail: 1'b0, check_data: 1'b1};
      exp_rsp.push_back(r);
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && exp_apb.size() == 0 && bus.cmd_ready) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 0, 1);
  endtask

  // APB monitor: every write is a SETUP followed by one ACCESS, in model order.
  initial begin
    bit       prev_setup;
    apb_exp_t a;
    prev_setup = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_setup) check("apb_setup_to_access", bus.PSEL && bus.PENABLE, 1);
      if (bus.PSEL) begin
        check("apb_pwrite", bus.PWRITE, 1);
        if (exp_apb.size() == 0) begin
          check("apb_unexpected_psel", 0, 1);
        end else begin
          a = exp_apb[0];
          check("apb_addr", bus.PADDR, a.addr);
          check("apb_wdata", bus.PWDATA, a.data);
          if (bus.PENABLE) a = exp_apb.pop_front();
        end
      end else begin
        check("apb_penable_idle", bus.PENABLE, 0);
      end
      prev_setup = bus.PSEL && !bus.PENABLE;
    end
  end

  // Accelerator model: answers after the CTRL write as planned, and throws
  // stray completion pulses in states where they must be ignored.
  initial begin
    int    wait_left;
    bit    real_prev;
    plan_t cur;
    wait_left          = -1;
    real_prev          = 1'b0;
    bus.operation_done = 1'b0;
    bus.data_out       = '0;
    bus.num_of_errors  = '0;
    forever begin
      @(negedge clk);
      if (real_prev) check("rsp_valid_after_done", bus.rsp_valid, 1);
      real_prev          = 1'b0;
      bus.operation_done = 1'b0;
      bus.data_out       = $urandom;
      bus.num_of_errors  = 2'($urandom);
      if (!reset) begin
        wait_left = -1;
      end else if (wait_left > 0) begin
        wait_left--;
        if (wait_left == 0) begin
          bus.operation_done = 1'b1;
          bus.data_out       = cur.data;
          bus.num_of_errors  = cur.errs;
          real_prev          = 1'b1;
          wait_left          = -1;
        end
      end else if (bus.PSEL && bus.PENABLE && bus.PADDR == 20'h00) begin
        if (plan_q.size() == 0) begin
          check("plan_available", 0, 1);
        end else begin
          cur = plan_q.pop_front();
          if (cur.delay > 0) wait_left = cur.delay;
        end
      end else if (stray_en && (bus.PSEL || bus.rsp_valid || bus.cmd_ready) &&
                   $urandom_range(0, 2) == 0) begin
        bus.operation_done = 1'b1;
      end
    end
  end

  // Response monitor: fields match the head of the queue for as long as the
  // response is held; the entry retires on the handshake.
  initial begin
    rsp_exp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.rsp_valid) begin
        check("rsp_cmd_ready_low", bus.cmd_ready, 0);
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", 0, 1);
        end else begin
          e = exp_rsp[0];
          check("rsp_fail", bus.rsp_fail, e.fail);
          if (e.check_data) begin
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_errors", bus.rsp_errors, e.errs);
          end
          if (bus.rsp_ready) e = exp_rsp.pop_front();
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Main sequence: directed cases from the block's behaviour, then random traffic.
  initial begin
    bit found;
    int lat;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.cmd_width = '0;
    bus.cmd_noise = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_fail", bus.rsp_fail, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_errors", bus.rsp_errors, 0);

    // Encode example: four writes, then the accelerator answers 0x1A5.
    send_cmd(2'd0, 32'h0000_00A5, 2'd1, 32'h0, 2, 32'h0000_01A5, 2'd0);
    @(negedge clk);
    check("first_setup_psel", bus.PSEL, 1);
    check("first_setup_penable", bus.PENABLE, 0);
    check("first_setup_paddr", bus.PADDR, 20'h04);
    wait_drain();

    // Illegal op: no APB traffic, response one cycle after accept.
    send_cmd(2'd3, $urandom, 2'($urandom), $urandom, 0, '0, '0);
    @(negedge clk);
    check("illegal_rsp_valid", bus.rsp_valid, 1);
    check("illegal_rsp_fail", bus.rsp_fail, 1);
    check("illegal_psel", bus.PSEL, 0);
    wait_drain();

    // Response held for 5 cycles with rsp_ready low.
    auto_ready   = 1'b0;
    manual_ready = 1'b0;
    send_cmd(2'd1, 32'hDEAD_BEEF, 2'd2, 32'h0000_0011, 3, 32'hCAFE_F00D, 2'd2);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) found = 1'b1;
    end
    check("hold_rsp_seen", found, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_cmd_ready", bus.cmd_ready, 0);
    end
    @(posedge clk);
    #1 manual_ready = 1'b1;
    @(negedge clk);
    check("hold_last_cycle_cmd_ready", bus.cmd_ready, 0);
    @(negedge clk);
    check("hold_idle_cmd_ready", bus.cmd_ready, 1);
    check("hold_idle_rsp_valid", bus.rsp_valid, 0);
    manual_ready = 1'b0;
    auto_ready   = 1'b1;
    wait_drain();

    // Reset during the NOISE access abandons the transfer.
    send_cmd(2'd2, 32'h5A5A_5A5A, 2'd2, 32'h0000_0003, 3, 32'h1234_0000, 2'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.PSEL && bus.PENABLE && bus.PADDR == 20'h0C) found = 1'b1;
    end
    check("noise_access_seen", found, 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_psel", bus.PSEL, 0);
    check("midrst_penable", bus.PENABLE, 0);
    check("midrst_paddr", bus.PADDR, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    exp_apb.delete();
    plan_q.delete();
    exp_rsp.delete();
    @(negedge clk);
    #2 reset = 1'b1;
    send_cmd(2'd2, 32'h1234_5678, 2'd3, 32'h0000_0005, 2, 32'h8765_4321, 2'd3);
    @(negedge clk);
    check("restart_paddr", bus.PADDR, 20'h04);
    check("restart_psel", bus.PSEL, 1);
    wait_drain();

    // Random traffic, commands offered back-to-back.
    for (int n = 0; n < 40; n++) begin
      int       r;
      logic [1:0] op;
      r  = $urandom_range(0, 5);
      op = (r == 5) ? 2'd3 : 2'(r % 3);
      send_cmd(op, $urandom, 2'($urandom), $urandom, $urandom_range(1, 6),
               $urandom, 2'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_drain();

`ifdef ECC_APB_TIMEOUT_EN
    // No completion: fail response after 16 WAIT_DONE cycles (accept + 25).
    send_cmd(2'd0, $urandom, 2'd1, $urandom, -1, '0, '0);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) lat = k;
    end
    check("timeout_latency", lat, 25);
    wait_drain();
`else
    lat = 0;
`endif

    check("end_apb_queue_empty", exp_apb.size(), 0);
    check("end_rsp_queue_empty", exp_rsp.size(), 0);
    check("end_plan_queue_empty", plan_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
